pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 each, ID source register numbers.
REQ-005 SHALL have ports id_use_rs and id_use_rt, input, 1 each, ID instruction reads that source.
REQ-006 SHALL have ports dec_regwrite, dec_memtoreg, dec_memwrite, dec_jump, input, 1 each, decoder outputs for the ID instruction.
REQ-007 SHALL have port dec_dst, input, 5, ID destination register after RegDst select.
REQ-008 SHALL have port ex_br_taken, input, 1, EX-stage branch-equal resolved taken.
REQ-009 SHALL have port mem_ready, input, 1, data memory completes the current access.
REQ-010 SHALL have port mem_req, output, 1, MEM stage holds a load or store.
REQ-011 SHALL have ports stall_pc and stall_ifid, output, 1 each, hold PC and IF/ID.
REQ-012 SHALL have ports flush_ifid and flush_idex, output, 1 each, insert bubble.
REQ-013 SHALL have ports fwd_a and fwd_b, output, 2 each, EX operand source: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-014 SHALL have port stall_all, output, 1, freeze every pipeline register.

Function
REQ-015 SHALL track EX, MEM and WB entries internally, each holding valid, regwrite, memtoreg, memwrite and dst; dst 0 never counts as a writer.
REQ-016 SHALL advance tracking each cycle unless stall_all is set; a bubble enters EX when flush_idex or stall_ifid is set.
REQ-017 SHALL assert stall_pc, stall_ifid and flush_idex for exactly one cycle on load-use: EX entry has memtoreg, and its dst matches a used ID source.
REQ-018 SHALL drive fwd_x = 10 when the MEM entry writes the EX operand register, else 01 when the WB entry does, else 00; MEM has priority.
REQ-019 SHALL assert flush_ifid and flush_idex in the cycle ex_br_taken is 1, and flush_ifid alone when dec_jump and id_valid are 1.
REQ-020 SHALL let a branch flush override a load-use stall in the same cycle: no stall, both flushes.
REQ-021 SHALL drive mem_req = 1 while the MEM entry is a load or store.
REQ-022 SHALL use FSM RUN/MWAIT: RUN->MWAIT when mem_req=1 and mem_ready=0; MWAIT->RUN when mem_ready=1; stall_all = 1 in MWAIT and in that RUN cycle.
REQ-023 SHALL suppress all flushes and load-use stalls while stall_all=1, and re-evaluate them after release.
REQ-024 SHALL deliver all outputs combinationally from state and inputs with zero added latency.

Reset
REQ-025 SHALL clear all tracking entries to invalid and the FSM to RUN on rst_n low, regardless of clk.
REQ-026 SHALL hold every output at 0 (fwd 00) during reset; reset mid-MWAIT abandons the access.

Configuration
REQ-027 SHALL honour macro PIPE_HAZARD_FWD_EN: defined gives forwarding per REQ-018.
REQ-028 SHALL, without PIPE_HAZARD_FWD_EN, tie fwd_a/fwd_b to 00 and replace REQ-017 with a stall (stall_pc, stall_ifid, flush_idex) while any valid EX, MEM or WB writer matches a used ID source.

Structure
REQ-029 SHALL take the fwd encodings, FSM state encodings and tracking-entry typedef from shared package cpu_pkg.
REQ-030 SHALL place the per-operand forward/match compare in sub-module hazard_fwd_sel, instantiated twice.

Verification
REQ-031 SHALL cover: lw $8 then add $9,$8,$10 -> one-cycle stall_pc, stall_ifid and flush_idex, then fwd_a = 01.
REQ-032 SHALL cover: add $3 then sub $4,$3,$3 back-to-back -> fwd_a = fwd_b = 10, no stall; with $0 as dst -> 00.
REQ-033 SHALL cover: ex_br_taken = 1 with a load-use pending -> flush_ifid and flush_idex = 1, stall_pc = 0.
REQ-034 SHALL cover: sw in MEM with mem_ready low for 3 cycles -> stall_all = 1 for 3 cycles, tracking frozen, released on the ready cycle.
REQ-035 SHALL cover: rst_n dropped during MWAIT -> all outputs 0 immediately, RUN after release.
REQ-036 SHALL cover, with the macro undefined: add $5 then or $6,$5,$0 -> 3 stall cycles, fwd always 00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forwarding encodings, memory-wait FSM states and the
// per-stage tracking entry used by the hazard controller.
package cpu_pkg;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef enum logic {
    StRun   = 1'b0,
    StMwait = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [4:0] dst;
  } stage_t;

  // $0 is hardwired, so an instruction targeting it never produces a value to wait for.
  function automatic logic is_writer(input logic valid, input logic regwrite,
                                     input logic [4:0] dst);
    return valid & regwrite & (dst != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand hazard compare: EX operand forward select and ID source stall match.
// Forwarding logic exists only when PIPE_HAZARD_FWD_EN is defined.
module hazard_fwd_sel
  import cpu_pkg::*;
(
  input  logic       i_id_use,
  input  logic [4:0] i_id_src,
  input  logic       i_ex_use,
  input  logic [4:0] i_ex_src,
  input  logic       i_ex_wr,
  input  logic       i_ex_load,
  input  logic [4:0] i_ex_dst,
  input  logic       i_mem_wr,
  input  logic [4:0] i_mem_dst,
  input  logic       i_wb_wr,
  input  logic [4:0] i_wb_dst,
  output logic [1:0] o_fwd,
  output logic       o_stall
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_id_use & i_ex_wr & (i_ex_dst == i_id_src);

`ifdef PIPE_HAZARD_FWD_EN
  assign w_mem_hit = i_ex_use & i_mem_wr & (i_mem_dst == i_ex_src);
  assign w_wb_hit  = i_ex_use & i_wb_wr & (i_wb_dst == i_ex_src);
  // MEM holds the younger result, so it wins over WB.
  assign o_fwd     = w_mem_hit ? FwdMem : (w_wb_hit ? FwdWb : FwdRf);
  assign o_stall   = w_ex_hit & i_ex_load;
`else
  logic w_unused_ex;

  // Without bypass paths the ID reader must wait until every older writer has retired.
  assign w_mem_hit   = i_id_use & i_mem_wr & (i_mem_dst == i_id_src);
  assign w_wb_hit    = i_id_use & i_wb_wr & (i_wb_dst == i_id_src);
  assign o_fwd       = FwdRf;
  assign o_stall     = w_ex_hit | w_mem_hit | w_wb_hit;
  assign w_unused_ex = ^{i_ex_use, i_ex_src, i_ex_load};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, forwarding, branch/jump flush and
// data-memory wait freeze. Define PIPE_HAZARD_FWD_EN to enable operand forwarding.
module pipe_hazard_ctrl
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic       i_dec_regwrite,
  input  logic       i_dec_memtoreg,
  input  logic       i_dec_memwrite,
  input  logic       i_dec_jump,
  input  logic [4:0] i_dec_dst,
  input  logic       i_ex_br_taken,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_stall_pc,
  output logic       o_stall_ifid,
  output logic       o_flush_ifid,
  output logic       o_flush_idex,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_stall_all
);

  stage_t     r_ex, r_mem, r_wb;
  logic [4:0] r_ex_rs, r_ex_rt;
  logic       r_ex_use_rs, r_ex_use_rt;
  mem_state_e r_state, w_state_next;

  stage_t w_id_entry;
  logic   w_ex_wr, w_mem_wr, w_wb_wr;
  logic   w_stall_a, w_stall_b, w_load_use, w_active, w_bubble;
  logic   w_unused_wb;

  assign w_ex_wr     = is_writer(r_ex.valid, r_ex.regwrite, r_ex.dst);
  assign w_mem_wr    = is_writer(r_mem.valid, r_mem.regwrite, r_mem.dst);
  assign w_wb_wr     = is_writer(r_wb.valid, r_wb.regwrite, r_wb.dst);
  assign w_unused_wb = r_wb.memtoreg ^ r_wb.memwrite;

  assign w_id_entry = '{valid: i_id_valid, regwrite: i_dec_regwrite, memtoreg: i_dec_memtoreg,
                        memwrite: i_dec_memwrite, dst: i_dec_dst};

  hazard_fwd_sel u_sel_a (
    .i_id_use  (i_id_valid & i_id_use_rs),
    .i_id_src  (i_id_rs),
    .i_ex_use  (r_ex_use_rs),
    .i_ex_src  (r_ex_rs),
    .i_ex_wr   (w_ex_wr),
    .i_ex_load (r_ex.memtoreg),
    .i_ex_dst  (r_ex.dst),
    .i_mem_wr  (w_mem_wr),
    .i_mem_dst (r_mem.dst),
    .i_wb_wr   (w_wb_wr),
    .i_wb_dst  (r_wb.dst),
    .o_fwd     (o_fwd_a),
    .o_stall   (w_stall_a)
  );

  hazard_fwd_sel u_sel_b (
    .i_id_use  (i_id_valid & i_id_use_rt),
    .i_id_src  (i_id_rt),
    .i_ex_use  (r_ex_use_rt),
    .i_ex_src  (r_ex_rt),
    .i_ex_wr   (w_ex_wr),
    .i_ex_load (r_ex.memtoreg),
    .i_ex_dst  (r_ex.dst),
    .i_mem_wr  (w_mem_wr),
    .i_mem_dst (r_mem.dst),
    .i_wb_wr   (w_wb_wr),
    .i_wb_dst  (r_wb.dst),
    .o_fwd     (o_fwd_b),
    .o_stall   (w_stall_b)
  );

  assign o_mem_req = r_mem.valid & (r_mem.memtoreg | r_mem.memwrite);

  // The freeze lifts in the cycle the memory reports ready so the access retires exactly once.
  always_comb begin
    w_state_next = r_state;
    o_stall_all  = 1'b0;
    case (r_state)
      StRun: begin
        if (o_mem_req && !i_mem_ready) begin
          o_stall_all  = 1'b1;
          w_state_next = StMwait;
        end
      end
      StMwait: begin
        o_stall_all = ~i_mem_ready;
        if (i_mem_ready) begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StRun;
    endcase
  end

  // Flush/stall decisions are held off while frozen or in reset; a taken branch beats load-use.
  assign w_active     = i_rst_n & ~o_stall_all;
  assign w_load_use   = w_stall_a | w_stall_b;
  assign o_stall_pc   = w_active & w_load_use & ~i_ex_br_taken;
  assign o_stall_ifid = o_stall_pc;
  assign o_flush_idex = w_active & (i_ex_br_taken | w_load_use);
  assign o_flush_ifid = w_active & (i_ex_br_taken | (i_id_valid & i_dec_jump & ~w_load_use));
  assign w_bubble     = o_flush_idex | o_stall_ifid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StRun;
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!o_stall_all) begin
        r_mem   <= r_ex;
        r_wb    <= r_mem;
        r_ex_rs <= i_id_rs;
        r_ex_rt <= i_id_rt;
        if (w_bubble) begin
          r_ex        <= '0;
          r_ex_use_rs <= 1'b0;
          r_ex_use_rt <= 1'b0;
        end else begin
          r_ex        <= w_id_entry;
          r_ex_use_rs <= i_id_valid & i_id_use_rs;
          r_ex_use_rt <= i_id_valid & i_id_use_rt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt, dec_dst;
  logic       dec_regwrite, dec_memtoreg, dec_memwrite, dec_jump;
  logic       ex_br_taken, mem_ready;
  logic       mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex, stall_all;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_id_valid     (id_valid),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_use_rs    (id_use_rs),
    .i_id_use_rt    (id_use_rt),
    .i_dec_regwrite (dec_regwrite),
    .i_dec_memtoreg (dec_memtoreg),
    .i_dec_memwrite (dec_memwrite),
    .i_dec_jump     (dec_jump),
    .i_dec_dst      (dec_dst),
    .i_ex_br_taken  (ex_br_taken),
    .i_mem_ready    (mem_ready),
    .o_mem_req      (mem_req),
    .o_stall_pc     (stall_pc),
    .o_stall_ifid   (stall_ifid),
    .o_flush_ifid   (flush_ifid),
    .o_flush_idex   (flush_idex),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_stall_all    (stall_all)
  );

  typedef struct packed {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       m2r;
    logic       mw;
    logic [4:0] dst;
    logic       jmp;
  } id_t;

  typedef struct packed {
    id_t        id;
    logic       br;
    logic       rdy;
    logic [9:0] exp;
  } vec_t;

  localparam id_t        Nop  = '0;
  localparam logic [9:0] Zero = '0;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  function automatic id_t ins(input logic vld, input logic [4:0] d, input logic [4:0] s,
                              input logic [4:0] t, input logic us, input logic ut,
                              input logic rw, input logic m2r, input logic mw, input logic jmp);
    id_t r;
    r.vld = vld; r.dst = d; r.rs = s; r.rt = t; r.urs = us; r.urt = ut;
    r.rw = rw; r.m2r = m2r; r.mw = mw; r.jmp = jmp;
    return r;
  endfunction

  function automatic id_t alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return ins(1'b1, d, s, t, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic id_t lw(input logic [4:0] d, input logic [4:0] b);
    return ins(1'b1, d, b, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic id_t sw(input logic [4:0] b, input logic [4:0] s);
    return ins(1'b1, 5'd0, b, s, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic id_t jp(input logic v);
    return ins(v, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Expected outputs: mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_all
  function automatic logic [9:0] e(input logic mr, input logic spc, input logic sif,
                                   input logic fif, input logic fid, input logic [1:0] fa,
                                   input logic [1:0] fb, input logic sa);
    return {mr, spc, sif, fif, fid, fa, fb, sa};
  endfunction

  function automatic vec_t mk(input id_t d, input logic br, input logic rdy,
                              input logic [9:0] x);
    vec_t v;
    v.id = d; v.br = br; v.rdy = rdy; v.exp = x;
    return v;
  endfunction

  task automatic drive(input id_t d, input logic br, input logic rdy);
    id_valid     = d.vld;
    id_rs        = d.rs;
    id_rt        = d.rt;
    id_use_rs    = d.urs;
    id_use_rt    = d.urt;
    dec_regwrite = d.rw;
    dec_memtoreg = d.m2r;
    dec_memwrite = d.mw;
    dec_jump     = d.jmp;
    dec_dst      = d.dst;
    ex_br_taken  = br;
    mem_ready    = rdy;
  endtask

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = {mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_all};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (mem_req,stall_pc,stall_ifid,flush_ifid,flush_idex,fwd_a,fwd_b,stall_all)",
               name, act, exp);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(posedge clk);
    #1;
    drive(v.id, v.br, v.rdy);
    @(negedge clk);
    check(name, v.exp);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    // Post-reset, branch flush overriding a load-use, jump flush.
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(lw(5'd8, 5'd1), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd9, 5'd8, 5'd10), 1'b1, 1'b1, e(0, 0, 0, 1, 1, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, e(1, 0, 0, 0, 0, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(jp(1'b1), 1'b0, 1'b1, e(0, 0, 0, 1, 0, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(jp(1'b0), 1'b0, 1'b1, Zero));
    // Store waits three cycles in MEM; the pending branch flush is held until release.
    tbl.push_back(mk(sw(5'd2, 5'd3), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(alu(5'd11, 5'd12, 5'd13), 1'b1, 1'b0, e(1, 0, 0, 0, 0, 2'b00, 2'b00, 1)));
    end
    tbl.push_back(mk(alu(5'd11, 5'd12, 5'd13), 1'b1, 1'b1, e(1, 0, 0, 1, 1, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b0, Zero));
`ifdef PIPE_HAZARD_FWD_EN
    tbl.push_back(mk(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd4, 5'd3, 5'd3), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 2'b10, 2'b10, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd4, 5'd0, 5'd0), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(lw(5'd8, 5'd1), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b1, e(0, 1, 1, 0, 1, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(alu(5'd9, 5'd8, 5'd10), 1'b0, 1'b1, e(1, 0, 0, 0, 0, 2'b00, 2'b00, 0)));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 2'b01, 2'b00, 0)));
    tbl.push_back(mk(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd3, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd4, 5'd3, 5'd5), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 2'b10, 2'b00, 0)));
`else
    tbl.push_back(mk(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, e(0, 1, 1, 0, 1, 2'b00, 2'b00, 0)));
    end
    tbl.push_back(mk(alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(Nop, 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(alu(5'd14, 5'd0, 5'd7), 1'b0, 1'b1, Zero));
    tbl.push_back(mk(ins(1'b1, 5'd15, 5'd14, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                     1'b0, 1'b1, Zero));
    tbl.push_back(mk(ins(1'b0, 5'd15, 5'd14, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
                     1'b0, 1'b1, Zero));
`endif

    // Outputs stay low in reset even with flush requests on the inputs.
    rst_n = 1'b1;
    drive(jp(1'b1), 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #6;
    check("reset_hold", Zero);
    @(negedge clk);
    drive(Nop, 1'b0, 1'b1);
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while waiting on memory abandons the access.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 drive(Nop, 1'b0, 1'b1);
    end
    step("mw_sw_id", mk(sw(5'd2, 5'd3), 1'b0, 1'b1, Zero));
    step("mw_sw_ex", mk(Nop, 1'b0, 1'b1, Zero));
    step("mw_enter", mk(Nop, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 2'b00, 2'b00, 1)));
    step("mw_wait", mk(Nop, 1'b0, 1'b0, e(1, 0, 0, 0, 0, 2'b00, 2'b00, 1)));
    #1;
    drive(jp(1'b1), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 check("mw_reset_async", Zero);
    @(posedge clk);
    #1 check("mw_reset_edge", Zero);
    @(negedge clk);
    drive(Nop, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("mw_after_rst0", mk(Nop, 1'b0, 1'b0, Zero));
    step("mw_after_rst1", mk(Nop, 1'b0, 1'b0, Zero));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
